rom_fetch_arbiter: RTL
======================

Name: rom_fetch_arbiter

Overview:
Sequences the instruction ROM (POS words x NUM_BITS, combinational read) and shares its single read port between two requesters. The first is the instruction-fetch path, which keeps a program counter and a 2-entry prefetch FIFO feeding decode. The second is a data read port used for loads from the constant/code region. The block sits between the ROM and the core front end and owns the ROM address bus.

Parameters:
POS, 1024, ROM depth in words; rom_addr width = $clog2(POS)
NUM_BITS, 32, ROM word width
RESET_PC, 32'h0000_0000, byte address of the first fetch after reset

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
halt  in  1  level; stop issuing new fetches
redirect  in  1  one-cycle pulse; flush and restart fetch
redirect_pc  in  32  new fetch byte address; bits [1:0] ignored
if_valid  out  1  if_instr/if_pc valid (FIFO head)
if_ready  in  1  decode accepts FIFO head
if_instr  out  NUM_BITS  fetched instruction
if_pc  out  32  byte address of if_instr
dreq_valid  in  1  data read request
dreq_addr  in  32  data byte address; bits [1:0] ignored
dreq_ready  out  1  combinational grant; request accepted this cycle
drsp_valid  out  1  one-cycle pulse, cycle after grant
drsp_data  out  NUM_BITS  data read result
rom_addr  out  $clog2(POS)  ROM word address
rom_dout  in  NUM_BITS  ROM read data (same cycle)
err  out  1  sticky out-of-range flag (see Optional Feature)

Behaviour:
- Reset (async): state=BOOT, fetch_pc=RESET_PC, FIFO count=0, last_grant=FETCH. Outputs: if_valid=0, if_instr=0, if_pc=0, drsp_valid=0, drsp_data=0, dreq_ready=0, rom_addr=0, err=0.
- Reset asserted mid-operation: FIFO contents and any in-flight drsp are dropped immediately; no partial response is produced.
- FSM states:
  - BOOT -> RUN at the first edge after RESET deasserts. No grants are issued in BOOT.
  - RUN -> HALTED when halt=1.
  - HALTED -> RUN when halt=0.
  - A redirect in HALTED updates fetch_pc and flushes the FIFO, but the state stays HALTED.
- Fetch request: fetch_req = (state==RUN) && (count<2) && !redirect. A same-cycle pop does not free a slot for that cycle.
- Data request: honoured in RUN and HALTED; never in BOOT.
- Arbitration, one grant per cycle:
  - Only one requester active: it wins.
  - Both active: round-robin on last_grant; the winner is the one not granted last.
  - last_grant updates only on a contended grant.
- rom_addr = granted address [$clog2(POS)+1:2]; holds its previous value when there is no grant.
- Fetch grant in cycle N:
  - At edge N: push {rom_dout, fetch_pc} into the FIFO; fetch_pc += 4.
  - if_valid is high from cycle N+1.
- Data grant in cycle N: dreq_ready=1 in N; drsp_valid=1 and drsp_data=rom_dout(N) in N+1 only. drsp_data holds its value afterwards.
- FIFO:
  - Pop when if_valid && if_ready.
  - Push and pop in the same cycle: count unchanged.
  - if_instr/if_pc show the head entry and hold when empty.
- Redirect (highest priority):
  - At the edge: FIFO count=0, fetch_pc={redirect_pc[31:2],2'b00}.
  - No fetch is granted in the redirect cycle, so a stale push cannot occur.
  - A data grant in the same cycle proceeds normally.
  - if_valid=0 in the cycle after redirect.
- Latency: first if_valid (pc=RESET_PC) appears in the 2nd cycle after RESET deasserts; each following cycle adds one entry while not stalled.
- Address wrap: the PC is 32-bit and wraps mod 2^32; ROM index bits above $clog2(POS) are ignored (aliasing).

Optional Feature:
ROM_OOB_CHECK_EN
- Defined:
  - Any granted address with byte addr >= POS*4 sets err=1 (sticky until RESET).
  - A fetch to such an address is not pushed, and the FSM moves to HALTED. It leaves HALTED only via redirect (-> RUN) or RESET.
  - A data access to such an address still gets drsp_valid, with drsp_data=0.
- Not defined: no checking, addresses alias, err tied to 0.

Test Plan:
- Reset release with ROM loaded from fibonacci.txt, if_ready=1 -> if_valid in 2nd cycle; if_instr sequence 0x10000197, 0x0001a383, 0x00818413, 0x00418493 with if_pc 0,4,8,12.
- if_ready=0 for 5 cycles -> count saturates at 2, if_pc stays 0x0; ready=1 -> 0x10000197 then 0x0001a383, nothing lost or duplicated.
- dreq_valid=1, dreq_addr=0x8 while fetch busy -> grants alternate fetch/data; drsp_valid one cycle after dreq_ready with drsp_data=0x00818413.
- redirect pulse, redirect_pc=0x6 while FIFO full -> next if_valid shows if_pc=0x4, if_instr=0x0001a383; no stale entries.
- halt=1 -> no further rom_addr changes from fetch; data read addr 0xC still returns 0x00418493; halt=0 resumes at the next sequential PC.
- RESET pulse mid-stream with FIFO full and a pending drsp -> all outputs 0 immediately; restart at RESET_PC. With ROM_OOB_CHECK_EN, redirect_pc=0x1000 -> err=1, FSM HALTED, no if_valid.

Source files
------------

// File: rtl/rom_fetch_arbiter_if.sv
// rom_fetch_arbiter_if: bundles the front-end, data-read and ROM bus signals
// of rom_fetch_arbiter. The slave modport is the arbiter's view. The master
// modport is the surrounding core/ROM view, which drives requests and rom_dout.
interface rom_fetch_arbiter_if #(
    parameter int POS      = 1024,
    parameter int NUM_BITS = 32
);
    localparam int AW = $clog2(POS);

    logic                halt;
    logic                redirect;
    logic [31:0]         redirect_pc;

    logic                if_valid;
    logic                if_ready;
    logic [NUM_BITS-1:0] if_instr;
    logic [31:0]         if_pc;

    logic                dreq_valid;
    logic [31:0]         dreq_addr;
    logic                dreq_ready;
    logic                drsp_valid;
    logic [NUM_BITS-1:0] drsp_data;

    logic [AW-1:0]       rom_addr;
    logic [NUM_BITS-1:0] rom_dout;

    logic                err;

    modport master (
        output halt, redirect, redirect_pc, if_ready, dreq_valid, dreq_addr, rom_dout,
        input  if_valid, if_instr, if_pc, dreq_ready, drsp_valid, drsp_data, rom_addr, err
    );

    modport slave (
        input  halt, redirect, redirect_pc, if_ready, dreq_valid, dreq_addr, rom_dout,
        output if_valid, if_instr, if_pc, dreq_ready, drsp_valid, drsp_data, rom_addr, err
    );
endinterface

// File: rtl/rom_fetch_arbiter.sv
// rom_fetch_arbiter: owns the single combinational read port of the
// instruction ROM. It shares that port between the instruction-fetch path
// (program counter plus a 2-entry prefetch FIFO feeding decode) and a data
// read port. Contended cycles alternate between the two requesters.
// Optional build macro ROM_OOB_CHECK_EN adds checking of granted addresses
// against the ROM size. The check drives a sticky err and halts fetch on an
// out-of-range fetch. Without the macro, addresses alias and err is 0.
module rom_fetch_arbiter #(
    parameter int          POS      = 1024,
    parameter int          NUM_BITS = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RESET,
    rom_fetch_arbiter_if.slave bus
);
    localparam int AW = $clog2(POS);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    typedef enum logic {
        GNT_FETCH = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    state_t              state;
    state_t              state_nxt;
    grant_t              last_grant;
    grant_t              last_grant_nxt;

    logic [31:0]         fetch_pc;
    logic [1:0]          count;
    logic                rd_ptr;
    logic                wr_ptr;
    logic [NUM_BITS-1:0] instr_mem [2];
    logic [31:0]         pc_mem    [2];
    logic [NUM_BITS-1:0] head_instr;
    logic [31:0]         head_pc;
    logic [NUM_BITS-1:0] hold_instr;
    logic [31:0]         hold_pc;
    logic                fifo_nonempty;

    logic [AW-1:0]       rom_addr_q;
    logic [AW-1:0]       rom_addr_nxt;

    logic                fetch_req;
    logic                data_req;
    logic                fetch_gnt;
    logic                data_gnt;
    logic                push;
    logic                pop;

    logic                fetch_oob;
    logic                data_oob;
    logic                oob_halt;

    logic                rsp_vld_p1;
    logic [NUM_BITS-1:0] rsp_data_p1;

    // Out-of-range detection on the two candidate addresses.
`ifdef ROM_OOB_CHECK_EN
    localparam logic [32:0] ROM_BYTES = 33'(POS) * 33'd4;

    logic err_q;

    assign fetch_oob = ({1'b0, fetch_pc} >= ROM_BYTES);
    assign data_oob  = ({1'b0, bus.dreq_addr} >= ROM_BYTES);
    assign bus.err   = err_q;

    // Sticky error flag and the "halted by a bad fetch" marker; only a
    // redirect (or reset) clears the marker and lets fetch run again.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            err_q    <= 1'b0;
            oob_halt <= 1'b0;
        end else begin
            if ((fetch_gnt && fetch_oob) || (data_gnt && data_oob)) begin
                err_q <= 1'b1;
            end
            if (bus.redirect) begin
                oob_halt <= 1'b0;
            end else if (fetch_gnt && fetch_oob) begin
                oob_halt <= 1'b1;
            end
        end
    end
`else
    assign fetch_oob = 1'b0;
    assign data_oob  = 1'b0;
    assign oob_halt  = 1'b0;
    assign bus.err   = 1'b0;
`endif

    // Request qualification and one-grant-per-cycle round-robin arbitration.
    // Fetch only looks at the pre-pop count, so a pop never opens a slot for
    // the same cycle; a redirect cycle never fetches so nothing stale lands.
    always_comb begin
        fetch_req      = (state == RUN) && (count != 2'd2) && !bus.redirect;
        data_req       = bus.dreq_valid && (state != BOOT);
        fetch_gnt      = 1'b0;
        data_gnt       = 1'b0;
        last_grant_nxt = last_grant;
        if (fetch_req && data_req) begin
            if (last_grant == GNT_FETCH) begin
                data_gnt       = 1'b1;
                last_grant_nxt = GNT_DATA;
            end else begin
                fetch_gnt      = 1'b1;
                last_grant_nxt = GNT_FETCH;
            end
        end else begin
            fetch_gnt = fetch_req;
            data_gnt  = data_req;
        end
    end

    // ROM word address follows the granted requester, otherwise holds.
    always_comb begin
        rom_addr_nxt = rom_addr_q;
        if (fetch_gnt) begin
            rom_addr_nxt = fetch_pc[AW+1:2];
        end else if (data_gnt) begin
            rom_addr_nxt = bus.dreq_addr[AW+1:2];
        end
    end

    assign bus.rom_addr   = rom_addr_nxt;
    assign bus.dreq_ready = data_gnt;

    assign push          = fetch_gnt && !fetch_oob;
    assign fifo_nonempty = (count != 2'd0);
    assign pop           = fifo_nonempty && bus.if_ready;

    // Next-state logic: BOOT lasts exactly one cycle after reset. halt moves
    // between RUN and HALTED. A bad fetch parks in HALTED until a redirect.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                if ((fetch_gnt && fetch_oob) || bus.halt) begin
                    state_nxt = HALTED;
                end
            end
            HALTED: begin
                if (oob_halt) begin
                    if (bus.redirect) begin
                        state_nxt = RUN;
                    end
                end else if (!bus.halt) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Control state: FSM, arbitration history, PC and FIFO bookkeeping.
    // A redirect wins over everything and empties the FIFO.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= BOOT;
            last_grant <= GNT_FETCH;
            fetch_pc   <= RESET_PC;
            count      <= 2'd0;
            rd_ptr     <= 1'b0;
            wr_ptr     <= 1'b0;
            rom_addr_q <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            rom_addr_q <= rom_addr_nxt;
            if (bus.redirect) begin
                fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
                wr_ptr   <= 1'b0;
            end else begin
                if (push) begin
                    fetch_pc <= fetch_pc + 32'd4;
                    wr_ptr   <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    // ---- fetch stage boundary: ROM word captured into the prefetch FIFO ----
    // FIFO payload storage; validity is carried by count, so no reset here.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[wr_ptr] <= bus.rom_dout;
            pc_mem[wr_ptr]    <= fetch_pc;
        end
    end

    assign head_instr   = instr_mem[rd_ptr];
    assign head_pc      = pc_mem[rd_ptr];
    assign bus.if_valid = fifo_nonempty;
    assign bus.if_instr = fifo_nonempty ? head_instr : hold_instr;
    assign bus.if_pc    = fifo_nonempty ? head_pc    : hold_pc;

    // Remember the last head shown so the decode outputs hold while empty.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hold_instr <= '0;
            hold_pc    <= '0;
        end else if (fifo_nonempty) begin
            hold_instr <= head_instr;
            hold_pc    <= head_pc;
        end
    end

    // ---- data stage boundary: response registered one cycle after grant ----
    // drsp_valid pulses for one cycle; drsp_data keeps the last result.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rsp_vld_p1  <= 1'b0;
            rsp_data_p1 <= '0;
        end else begin
            rsp_vld_p1 <= data_gnt;
            if (data_gnt) begin
                rsp_data_p1 <= data_oob ? '0 : bus.rom_dout;
            end
        end
    end

    assign bus.drsp_valid = rsp_vld_p1;
    assign bus.drsp_data  = rsp_data_p1;
endmodule
